// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - load-once local-bus UART transmitter, fixed 11-bit frame
module uart_tx_core #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [7:0] data,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic [3:0] baud_val,
    output logic       txrdy,
    output logic       tx
);

    localparam int DIV_W = $clog2(CLK_HZ / 300 + 2);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        shift_q;
    logic [3:0]         bit_cnt;
    logic [DIV_W-1:0]   baud_cnt;
    logic [DIV_W-1:0]   div_q;
    logic               load;
    logic               baud_tick;
    logic               last_tick;
    logic               par;
    logic [1:0]         hi_bits;
    logic [10:0]        frame;

    // Rounded clock divisor for each baud select code.
    function automatic logic [DIV_W-1:0] div_for(input logic [3:0] sel);
        int baud;
        case (sel)
            4'd0:    baud = 300;
            4'd1:    baud = 1200;
            4'd2:    baud = 2400;
            4'd3:    baud = 4800;
            4'd4:    baud = 9600;
            4'd5:    baud = 19200;
            4'd6:    baud = 38400;
            4'd7:    baud = 57600;
            4'd9:    baud = 230400;
            4'd10:   baud = 460800;
            4'd11:   baud = 921600;
            default: baud = 115200;
        endcase
        return DIV_W'((CLK_HZ + baud / 2) / baud);
    endfunction

    // Parity covers only the data bits that actually go on the line.
    always_comb begin
        par   = (^(data & {bit8, 7'h7f})) ^ odd_n_even;
        hi_bits = 2'b11;
        case ({bit8, parity_en})
            2'b11:   hi_bits = {par, data[7]};
            2'b10:   hi_bits = {1'b1, data[7]};
            2'b01:   hi_bits = {1'b1, par};
            default: hi_bits = 2'b11;
        endcase
        frame = {1'b1, hi_bits, data[6:0], 1'b0};
    end

    assign baud_tick = (baud_cnt == div_q - DIV_W'(1));
    assign last_tick = (state_q == ST_BUSY) && baud_tick && (bit_cnt == 4'd10);
    assign load      = (state_q == ST_IDLE) && !cs && we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load)      state_d = ST_BUSY;
            ST_BUSY: if (last_tick) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Shifting in ones leaves the line idle-high once all 11 bits are out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            div_q    <= '0;
        end else if (load) begin
            shift_q  <= frame;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            div_q    <= div_for(baud_val);
        end else if (state_q == ST_BUSY) begin
            if (baud_tick) begin
                baud_cnt <= '0;
                shift_q  <= {1'b1, shift_q[10:1]};
                bit_cnt  <= last_tick ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                baud_cnt <= baud_cnt + DIV_W'(1);
            end
        end
    end

    assign txrdy = (state_q == ST_IDLE);
    assign tx    = shift_q[0];

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - scoreboard bench for uart_tx_core
module tb_uart_tx_core;

    logic       clk;
    logic       reset;
    logic       cs;
    logic       we;
    logic [7:0] data;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic [3:0] baud_val;
    logic       txrdy;
    logic       tx;

    typedef struct {
        logic [10:0] bits;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_busy = 0;

    uart_tx_core #(.CLK_HZ(100_000_000)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .we         (we),
        .data       (data),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .baud_val   (baud_val),
        .txrdy      (txrdy),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_div(input logic [3:0] sel);
        int rates[16];
        rates = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                  115200, 230400, 460800, 921600, 115200, 115200, 115200, 115200};
        return (100_000_000 + rates[sel] / 2) / rates[sel];
    endfunction

    // Expected line bits, index 0 = start bit.
    function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic b8,
                                              input logic pe, input logic odd);
        logic [10:0] f;
        logic        p;
        p = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < 7 || b8) p = p ^ d[i];
        if (odd) p = ~p;
        f[0] = 1'b0;
        for (int i = 0; i < 7; i++) f[i+1] = d[i];
        if (b8 && pe)       begin f[8] = d[7]; f[9] = p;    end
        else if (b8)        begin f[8] = d[7]; f[9] = 1'b1; end
        else if (pe)        begin f[8] = p;    f[9] = 1'b1; end
        else                begin f[8] = 1'b1; f[9] = 1'b1; end
        f[10] = 1'b1;
        return f;
    endfunction

    // Caller positions at a negedge; inputs are held for 'hold' cycles.
    task automatic write(input logic [7:0] d, input logic b8, input logic pe,
                         input logic odd, input logic [3:0] bv, input int hold,
                         input bit expect_load);
        exp_t e;
        cs = 1'b0; we = 1'b1;
        data = d; bit8 = b8; parity_en = pe; odd_n_even = odd; baud_val = bv;
        if (expect_load) begin
            e.bits = exp_frame(d, b8, pe, odd);
            e.n    = exp_div(bv);
            sb.push_back(e);
        end
        repeat (hold) @(negedge clk);
        we = 1'b0; cs = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (!(txrdy && !mon_busy && sb.size() == 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            chk("idle_timeout", 32'(c), 32'(budget - 1));
            sb.delete();
        end
    endtask

    // Monitor: each frame is checked at the first and last clock of every bit.
    initial begin : monitor
        exp_t e;
        int   cyc;
        forever begin
            @(negedge clk);
            if (reset && !txrdy) begin
                mon_busy = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_load", 32'd1, 32'd0);
                    e.bits = '1;
                    e.n    = 1;
                end else begin
                    e = sb.pop_front();
                end
                cyc = 0;
                while (!txrdy && reset && cyc < 11 * e.n + 16) begin
                    if (cyc < 11 * e.n && (cyc % e.n == 0 || cyc % e.n == e.n - 1))
                        chk($sformatf("bit%0d_c%0d", cyc / e.n, cyc % e.n),
                            32'(tx), 32'(e.bits[cyc / e.n]));
                    cyc++;
                    @(negedge clk);
                end
                if (reset) begin
                    chk("busy_len", 32'(cyc), 32'(11 * e.n));
                    chk("tx_idle_after", 32'(tx), 32'd1);
                end
                mon_busy = 0;
            end
        end
    end

    initial begin
        reset = 1'b0; cs = 1'b0; we = 1'b0;
        data = 8'h00; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; baud_val = 4'd11;

        // Reset held with writes attempted.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = ~we;
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_txrdy", 32'(txrdy), 32'd1);
        end
        we = 1'b0; cs = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_txrdy", 32'(txrdy), 32'd1);

        // 8-bit odd parity at 115200, we held for 4 cycles, inputs changed mid-frame.
        @(negedge clk);
        write(8'hA5, 1'b1, 1'b1, 1'b1, 4'd8, 4, 1'b1);
        data = 8'h3C; bit8 = 1'b0; parity_en = 1'b0; odd_n_even = 1'b0; baud_val = 4'd0;
        wait_idle(12000);

        // Even parity 8-bit, then 7-bit even, then 7-bit no parity at 921600.
        @(negedge clk);
        write(8'hA5, 1'b1, 1'b1, 1'b0, 4'd11, 1, 1'b1);
        wait_idle(1400);
        @(negedge clk);
        write(8'h41, 1'b0, 1'b1, 1'b0, 4'd11, 1, 1'b1);
        wait_idle(1400);
        @(negedge clk);
        write(8'h55, 1'b0, 1'b0, 1'b0, 4'd11, 1, 1'b1);
        wait_idle(1400);

        // cs=1 blocks writes.
        cs = 1'b1; we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("cs_gate_txrdy", 32'(txrdy), 32'd1);
        end
        we = 1'b0;

        // Write while busy is ignored; write on the txrdy-rise cycle starts at once.
        @(negedge clk);
        write(8'hC3, 1'b1, 1'b1, 1'b1, 4'd11, 1, 1'b1);
        repeat (100) @(negedge clk);
        write(8'h0F, 1'b0, 1'b0, 1'b1, 4'd10, 3, 1'b0);
        begin
            int c;
            c = 0;
            while (!txrdy && c < 1400) begin
                @(negedge clk);
                c++;
            end
            chk("b2b_rise_seen", 32'(txrdy), 32'd1);
        end
        write(8'h96, 1'b1, 1'b0, 1'b0, 4'd11, 1, 1'b1);
        chk("b2b_start", 32'(txrdy), 32'd0);
        wait_idle(1400);

        // Reset during data bit 4, then a clean frame.
        @(negedge clk);
        write(8'h00, 1'b1, 1'b1, 1'b0, 4'd11, 1, 1'b1);
        repeat (5 * 109 + 50) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_txrdy", 32'(txrdy), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_abort_txrdy", 32'(txrdy), 32'd1);
        write(8'h5A, 1'b1, 1'b1, 1'b1, 4'd11, 1, 1'b1);
        wait_idle(1400);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
